// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch pointer, issues in-order memory reads,
// queues returned words with their addresses and hands them to decode.
module instr_fetch_unit #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    output logic [AW-1:0] fetch_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEP = CW'(DEPTH);

    typedef enum logic [1:0] {RUN, STALL, REDIR} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               count_q, count_d, outs_q, outs_d, disc_q, disc_d;
    logic [AW-1:0]               pc_q, pc_d;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d, tagw_q, tagr_q;
    logic [DEPTH-1:0][DW-1:0]    qdata_q;
    logic [DEPTH-1:0][AW-1:0]    qpc_q, tag_q;
    logic [CW-1:0]               credit, credit_d;
    logic                        grant, push, pop, drop;

    assign credit   = count_q + outs_q;
    assign credit_d = count_d + outs_d;

    // Gated with RST_n so the request is low while reset is held.
    assign mem_req  = RST_n && !redirect && (state_q == RUN) && (credit < DEP);
    assign mem_addr = pc_q;
    assign fetch_pc = pc_q;
    assign grant    = mem_req && mem_gnt;
    assign pop      = (count_q != '0) && instr_ready && !redirect;
    assign drop     = mem_rvalid && ((disc_q != '0) || redirect);
    assign push     = mem_rvalid && !drop;

    assign instr_valid = (count_q != '0);
    assign instr_data  = qdata_q[head_q];
    assign instr_pc    = qpc_q[head_q];

    always_comb begin
        pc_d    = pc_q;
        disc_d  = disc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        outs_d  = outs_q + CW'(grant) - CW'(mem_rvalid);
        count_d = count_q + CW'(push) - CW'(pop);
        if (grant)                        pc_d   = pc_q + AW'(1);
        if (mem_rvalid && disc_q != '0)   disc_d = disc_q - CW'(1);
        if (push)                         tail_d = tail_q + PW'(1);
        if (pop)                          head_d = head_q + PW'(1);
        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect) begin
            pc_d    = redirect_addr;
            disc_d  = outs_d;
            count_d = '0;
            head_d  = tail_q;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = REDIR;
        end else begin
            case (state_q)
                RUN:     if (grant && credit_d == DEP) state_d = STALL;
                STALL:   if (credit_d < DEP)           state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= RUN;
            count_q <= '0;
            outs_q  <= '0;
            disc_q  <= '0;
            pc_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            tagw_q  <= '0;
            tagr_q  <= '0;
            qdata_q <= '0;
            qpc_q   <= '0;
            tag_q   <= '0;
        end else begin
            assert (!mem_rvalid || outs_q != '0);
            assert (!push || count_q != DEP);
            state_q <= state_d;
            count_q <= count_d;
            outs_q  <= outs_d;
            disc_q  <= disc_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            // Tag FIFO is never flushed: dropped returns still consume their entry.
            if (grant) begin
                tag_q[tagw_q] <= pc_q;
                tagw_q        <= tagw_q + PW'(1);
            end
            if (mem_rvalid) tagr_q <= tagr_q + PW'(1);
            if (push) begin
                qdata_q[tail_q] <= mem_rdata;
                qpc_q[tail_q]   <= tag_q[tagr_q];
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized memory/decode with a queue-level
// reference model checked every cycle, plus literal scenario checks.
module tb_instr_fetch_unit;
    localparam int AW = 8, DW = 16, DEPTH = 4;

    logic          clk = 0;
    logic          RST_n = 0;
    logic          redirect = 0;
    logic [AW-1:0] redirect_addr = '0;
    logic          mem_req, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr, fetch_pc, instr_pc;
    logic [DW-1:0] mem_rdata, instr_data;
    logic          instr_valid, instr_ready = 0;

    instr_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .RST_n(RST_n), .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int ep; int due; } pend_t;
    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] d; } ent_t;

    pend_t         pending[$];
    ent_t          mq[$];
    int            grant_log[$], pop_log[$];
    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0, epoch = 0, dropped = 0;
    int            gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic [AW-1:0] exp_fetch = '0;
    logic          prev_redir = 0;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return {a ^ 8'h5A, ~a} + 16'h1234;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory model: grants queue up, returns come back in order after 1..N cycles.
    initial begin
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = (int'($urandom_range(99)) < gnt_pct);
            if (RST_n && pending.size() != 0 && pending[0].due <= cyc) begin
                mem_rvalid = 1;
                mem_rdata  = rom(pending[0].addr);
            end else begin
                mem_rvalid = 0;
                mem_rdata  = DW'($urandom);
            end
        end
    end

    // Compare current outputs with the model, then apply this cycle's events.
    always @(negedge clk) begin
        if (!RST_n) begin
            chk("rst_mem_req", mem_req, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_fetch_pc", fetch_pc, 0);
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_instr_data", instr_data, 0);
            pending.delete(); mq.delete(); grant_log.delete(); pop_log.delete();
            exp_fetch = '0; prev_redir = 0; dropped = 0;
        end else begin
            ent_t  e;
            pend_t p;
            chk("fetch_pc", fetch_pc, exp_fetch);
            chk("mem_addr", mem_addr, exp_fetch);
            chk("instr_valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("instr_data", instr_data, mq[0].d);
            end
            if (redirect || prev_redir) chk("req_in_redirect", mem_req, 0);
            if (mem_req) chk("credit_ok", (pending.size() + mq.size()) < DEPTH, 1);
            if (mq.size() != 0 && instr_ready && !redirect) begin
                pop_log.push_back(int'(instr_pc));
                void'(mq.pop_front());
            end
            if (mem_rvalid) begin
                if (pending.size() == 0) begin
                    chk("spurious_rvalid", 1, 0);
                end else begin
                    p = pending.pop_front();
                    if (p.ep == epoch && !redirect) begin
                        e.pc = p.addr; e.d = rom(p.addr);
                        mq.push_back(e);
                    end else dropped++;
                end
            end
            if (mem_req && mem_gnt) begin
                grant_log.push_back(int'(mem_addr));
                p.addr = exp_fetch; p.ep = epoch;
                p.due  = cyc + int'($urandom_range(lat_max, lat_min));
                pending.push_back(p);
                exp_fetch = exp_fetch + 8'd1;
            end
            if (redirect) begin
                epoch++;
                mq.delete();
                exp_fetch = redirect_addr;
            end
            prev_redir = redirect;
        end
        cyc++;
    end

    task automatic do_reset();
        RST_n = 0; redirect = 0;
        repeat (2) @(posedge clk);
        #1 RST_n = 1;
    endtask

    task automatic wait_pending(input int n, input string nm);
        int i;
        for (i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (pending.size() == n) break;
        end
        if (i == 50) chk(nm, pending.size(), n);
    endtask

    function automatic int at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        int lows;
        // 1: free run, consecutive pcs, request never drops
        gnt_pct = 100; lat_min = 1; lat_max = 1; instr_ready = 1;
        do_reset();
        lows = 0;
        repeat (20) begin @(posedge clk); #2; if (!mem_req) lows++; end
        chk("t1_req_low_cycles", lows, 0);
        chk("t1_pop0", at(pop_log, 0), 0);
        chk("t1_pop4", at(pop_log, 4), 4);
        chk("t1_pop9", at(pop_log, 9), 9);

        // 2: decode stalled -> DEPTH grants then stall; one pop frees one request
        instr_ready = 0;
        do_reset();
        repeat (15) @(posedge clk);
        #2;
        chk("t2_grants", grant_log.size(), 4);
        chk("t2_grant3", at(grant_log, 3), 3);
        chk("t2_stall_req", mem_req, 0);
        @(posedge clk); #1 instr_ready = 1;
        @(posedge clk); #1 instr_ready = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("t2_grants_after", grant_log.size(), 5);
        chk("t2_grant4", at(grant_log, 4), 4);
        chk("t2_pops", pop_log.size(), 1);

        // 3: redirect with 3 reads outstanding
        instr_ready = 1; lat_min = 5; lat_max = 5;
        do_reset();
        wait_pending(3, "t3_reach_outstanding");
        redirect = 1; redirect_addr = 8'h40;
        @(posedge clk); #1 redirect = 0;
        #1 chk("t3_valid_after_redir", instr_valid, 0);
        repeat (25) @(posedge clk);
        chk("t3_dropped", dropped, 3);
        chk("t3_first_pop", at(pop_log, 0), 8'h40);
        chk("t3_grant3", at(grant_log, 3), 8'h40);

        // 4: address wrap
        gnt_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        redirect = 1; redirect_addr = 8'hFE; gnt_pct = 100;
        @(posedge clk); #1 redirect = 0;
        repeat (12) @(posedge clk);
        chk("t4_g0", at(grant_log, 0), 8'hFE);
        chk("t4_g1", at(grant_log, 1), 8'hFF);
        chk("t4_g2", at(grant_log, 2), 8'h00);
        chk("t4_g3", at(grant_log, 3), 8'h01);
        chk("t4_p1", at(pop_log, 1), 8'hFF);
        chk("t4_p3", at(pop_log, 3), 8'h01);

        // 5: random traffic and redirects
        gnt_pct = 30; lat_min = 1; lat_max = 5;
        do_reset();
        repeat (3000) begin
            @(posedge clk); #1;
            instr_ready   = $urandom_range(1);
            redirect      = ($urandom_range(49) == 0);
            redirect_addr = AW'($urandom);
        end
        redirect = 0;
        chk("t5_progress", pop_log.size() > 100, 1);

        // 6: reset mid-burst
        gnt_pct = 100; lat_min = 4; lat_max = 4; instr_ready = 0;
        do_reset();
        wait_pending(2, "t6_reach_outstanding");
        RST_n = 0;
        #1;
        chk("t6_req", mem_req, 0);
        chk("t6_valid", instr_valid, 0);
        chk("t6_fetch_pc", fetch_pc, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_instr_pc", instr_pc, 0);
        chk("t6_instr_data", instr_data, 0);
        gnt_pct = 0;
        repeat (2) @(posedge clk);
        #1 RST_n = 1;
        lows = 0;
        repeat (10) begin @(posedge clk); #2; if (instr_valid) lows++; end
        chk("t6_no_late_push", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
